// File: rtl/mac_acc_drain_if.sv
// Handshake bundle between a PE row, the accumulator drain block and the
// requantise/write-back path.
//   master : the environment (PE row driving words, sink accepting lanes)
//   slave  : the drain block itself
interface mac_acc_drain_if #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [1:0]       out_lane;
    logic             out_last;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_lane, out_last
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_lane, out_last
    );
endinterface

// File: rtl/mac_acc_drain.sv
// mac_acc_drain: captures one packed accumulator word from a PE row, splits
// it into 2 (mode 0) or 4 (mode 1) signed lanes, sign-extends each lane to
// OUT_W and streams them out one per handshake. A one-cycle pe_clr pulse
// follows every capture so the PE can restart accumulation.
// Optional: define MAC_ACC_DRAIN_RELU_EN to clamp negative lanes to zero.
module mac_acc_drain #(
    parameter int PIXEL_W_88 = 24,
    parameter int PIXEL_W_18 = 16,
    parameter int IN_W       = 64,
    parameter int OUT_W      = 24,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    mac_acc_drain_if.slave   bus,
    output logic             pe_clr,
    output logic [CNT_W-1:0] word_cnt
);
    localparam int NL_18 = 4;
    localparam int NL_88 = 2;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                       state;
    logic [IN_W-1:0]              hold;
    logic                         mode_q;
    logic [1:0]                   lane;
    logic                         last_q;
    logic                         valid_q;

    logic [NL_18-1:0][OUT_W-1:0]  lanes_18;
    logic [NL_88-1:0][OUT_W-1:0]  lanes_88;
    logic [OUT_W-1:0]             lane_sel;
    logic [OUT_W-1:0]             lane_out;
    logic                         fire;
    logic                         capture;
    logic [1:0]                   last_idx;
    logic [1:0]                   lane_nxt;

    // Sign-extend every candidate lane straight out of the hold register.
    for (genvar k = 0; k < NL_18; k++) begin : g_l18
        logic signed [PIXEL_W_18-1:0] raw;
        assign raw         = $signed(hold[k*PIXEL_W_18 +: PIXEL_W_18]);
        assign lanes_18[k] = OUT_W'(raw);
    end

    for (genvar k = 0; k < NL_88; k++) begin : g_l88
        logic signed [PIXEL_W_88-1:0] raw;
        assign raw         = $signed(hold[k*PIXEL_W_88 +: PIXEL_W_88]);
        assign lanes_88[k] = OUT_W'(raw);
    end

    assign lane_sel = mode_q ? lanes_18[lane] : lanes_88[lane[0]];

`ifdef MAC_ACC_DRAIN_RELU_EN
    assign lane_out = lane_sel[OUT_W-1] ? '0 : lane_sel;
`else
    assign lane_out = lane_sel;
`endif

    assign fire     = valid_q && bus.out_ready;
    // A new word can be taken while idle, or in the same cycle the last lane
    // leaves, which keeps back-to-back words bubble-free.
    assign bus.in_ready = !reset && ((state == IDLE) || (fire && last_q));
    assign capture  = bus.in_valid && bus.in_ready;
    assign last_idx = mode_q ? 2'd3 : 2'd1;
    assign lane_nxt = lane + 2'd1;

    assign bus.out_valid = valid_q;
    assign bus.out_data  = valid_q ? lane_out : '0;
    assign bus.out_lane  = lane;
    assign bus.out_last  = last_q;

    // Drain FSM: capture, per-lane advance, word count and PE clear pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hold     <= '0;
            mode_q   <= 1'b0;
            lane     <= 2'd0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            pe_clr   <= 1'b0;
            word_cnt <= '0;
        end else begin
            pe_clr <= capture;
            if (fire && last_q)
                word_cnt <= word_cnt + CNT_W'(1);

            if (capture) begin
                // Lane 0 is never the last lane in either mode.
                state   <= DRAIN;
                hold    <= bus.in_data;
                mode_q  <= bus.in_mode;
                lane    <= 2'd0;
                last_q  <= 1'b0;
                valid_q <= 1'b1;
            end else if (fire) begin
                if (last_q) begin
                    state   <= IDLE;
                    lane    <= 2'd0;
                    last_q  <= 1'b0;
                    valid_q <= 1'b0;
                end else begin
                    lane   <= lane_nxt;
                    last_q <= (lane_nxt == last_idx);
                end
            end
        end
    end
endmodule

// File: doc/mac_acc_drain.md
Name: mac_acc_drain

Overview:
- Read-side companion to the packed-accumulator MAC PE. It accepts one packed accumulator word from a PE row together with the mode the word was built in.
- It splits the word into signed lanes, sign-extends each lane to a common width and streams the lanes out one per handshake.
- It issues a one-cycle clear pulse so the PE can restart accumulation once its word has been captured.
- It sits between a PE row and the requantise/write-back path.

Parameters:
- PIXEL_W_88, 24, lane width in mode 0 (two lanes).
- PIXEL_W_18, 16, lane width in mode 1 (four lanes).
- IN_W, 64, packed input width; must be >= 4*PIXEL_W_18 and >= 2*PIXEL_W_88.
- OUT_W, 24, output lane width; must be >= PIXEL_W_88.
- CNT_W, 16, width of the drained-word counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  packed word available.
- in_ready  output  1  block can capture a word this cycle.
- in_data  input  IN_W  packed accumulator word.
- in_mode  input  1  0 = two PIXEL_W_88 lanes; 1 = four PIXEL_W_18 lanes.
- pe_clr  output  1  one-cycle pulse on each capture (clears the PE accumulator).
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the lane.
- out_data  output  OUT_W  sign-extended lane value.
- out_lane  output  2  lane index of out_data.
- out_last  output  1  current lane is the final lane of the word.
- word_cnt  output  CNT_W  number of fully drained words.

Behaviour:
- Reset: clk, reset synchronous active-high. All outputs are 0 and the state is IDLE.
- State machine:
  - IDLE: in_ready=1, out_valid=0.
  - DRAIN: out_valid=1.
- Capture (in_valid && in_ready):
  - Latch in_data and in_mode into the hold register.
  - Lane index = 0; pe_clr=1 in the following cycle.
  - Go to DRAIN. Lane 0 appears on out_data exactly 1 cycle after the capture edge.
- Lane extraction:
  - Mode 0: lane k = hold[k*PIXEL_W_88 +: PIXEL_W_88], k = 0..1; bits above 2*PIXEL_W_88 are ignored.
  - Mode 1: lane k = hold[k*PIXEL_W_18 +: PIXEL_W_18], k = 0..3.
  - Every lane is sign-extended to OUT_W.
- out_last = 1 when the lane index equals (mode ? 3 : 1).
- Lane advance:
  - The lane index advances only on out_valid && out_ready.
  - While out_ready=0, out_data, out_lane and out_last are held stable.
- Last-lane handshake:
  - word_cnt increments and wraps modulo 2^CNT_W.
  - If in_valid is not high that cycle, the state returns to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). in_ready is combinational from out_ready.
- Back-to-back: a capture coinciding with the last-lane handshake loads the new word, and the new word's lane 0 is presented the next cycle with no bubble (out_valid stays 1).
- Mode handling: the latched mode governs the whole drain. in_mode changes outside a capture have no effect.
- pe_clr:
  - Exactly one pulse per captured word.
  - Never asserted during reset or in the cycle immediately after a reset.
- Reset mid-drain: the word in flight is discarded, with no partial out_last. word_cnt returns to 0 and the block is in IDLE the cycle after reset deasserts.

Optional Feature:
- Macro: MAC_ACC_DRAIN_RELU_EN.
- When defined: any lane whose sign bit is 1 is output as 0. out_lane, out_last, lane count and word_cnt are unchanged.
- When undefined: lanes are output as sign-extended values with no clamping.

Test Plan:
- Mode 0, in_data=64'h0000_FFFFFE_000005, out_ready=1 -> lane0=24'h000005 (last=0), lane1=24'hFFFFFE (last=1), word_cnt=1, single pe_clr pulse.
- Mode 1, in_data=64'h8000_7FFF_FFFF_0001 -> lanes 24'h000001, 24'hFFFFFF, 24'h007FFF, 24'hFF8000, with out_last only on lane 3. With MAC_ACC_DRAIN_RELU_EN: 1, 0, 24'h007FFF, 0.
- Backpressure: hold out_ready=0 for 5 cycles on lane 1 in mode 1 -> out_data/out_lane stable, in_ready=0, no lane skipped or duplicated.
- Back-to-back: in_valid held high with three mode-1 words, out_ready=1 -> 12 consecutive valid cycles, no bubble, 3 pe_clr pulses, word_cnt=3.
- Reset asserted after lane 1 of a mode-1 word -> out_valid=0 and word_cnt=0 next cycle; a new mode-0 word then drains from lane 0.
- Mode change: in_mode toggles during a mode-0 drain -> exactly 2 lanes emitted, 24-bit extraction unaffected.
